// File: rtl/hsv_core_pkg.sv
// hsv_core_pkg: shared core types and the register-index to reg_mask decode.
package hsv_core_pkg;
  localparam int RegAmount = 31;
  typedef logic [RegAmount-1:0] reg_mask;
  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } issue_data_t;
  // x0 is never tracked, so index 0 decodes to an empty mask.
  function automatic reg_mask reg_decode(input logic [4:0] idx);
    reg_decode = '0;
    if (idx != 5'd0) reg_decode[idx - 5'd1] = 1'b1;
  endfunction
endpackage

// File: rtl/hsv_core_issue_scoreboard.sv
// hsv_core_issue_scoreboard: holds issue on register hazards against outstanding writes,
// tracks pending destinations and counts hazard-stall cycles.
module hsv_core_issue_scoreboard
  import hsv_core_pkg::*;
(
  input  logic        clk_core,
  input  logic        rst_core_n,
  input  logic        flush_req,
  input  logic        stall_i,
  input  logic        valid_i,
  input  issue_data_t issue_data_i,
  input  reg_mask     mask_i,
  input  reg_mask     rd_mask_i,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_rd_addr_i,
  output logic        stall_o,
  output logic        valid_o,
  output issue_data_t out,
  output reg_mask     pending_o,
  output logic [31:0] hazard_cycles_o
);
  reg_mask     pending;
  reg_mask     wb_clr;
  logic        hazard;
  logic        fire;
  logic [31:0] hazard_cnt;
  // Hazard looks only at the registered pending set; a same-cycle writeback does not bypass.
  assign hazard          = valid_i & |(mask_i & pending);
  assign stall_o         = stall_i | hazard;
  assign fire            = valid_i & ~hazard & ~stall_i & ~flush_req;
  assign wb_clr          = wb_valid_i ? reg_decode(wb_rd_addr_i) : '0;
  assign pending_o       = pending;
  assign hazard_cycles_o = hazard_cnt;
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      pending    <= '0;
      valid_o    <= 1'b0;
      out        <= '0;
      hazard_cnt <= '0;
    end else begin
      pending <= flush_req ? '0 : (pending & ~wb_clr) | (fire ? rd_mask_i : '0);
      valid_o <= flush_req ? 1'b0 : stall_i ? valid_o : fire;
      if (fire) out <= issue_data_i;
      if (hazard & ~flush_req) hazard_cnt <= hazard_cnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_hsv_core_issue_scoreboard.sv
// tb_hsv_core_issue_scoreboard: directed scenarios plus random traffic against a register-level model.
module tb_hsv_core_issue_scoreboard;
  import hsv_core_pkg::*;
  logic        clk_core = 1'b0;
  logic        rst_core_n = 1'b1;
  logic        flush_req = 1'b0;
  logic        stall_i = 1'b0;
  logic        valid_i = 1'b0;
  issue_data_t issue_data_i = '0;
  reg_mask     mask_i = '0;
  reg_mask     rd_mask_i = '0;
  logic        wb_valid_i = 1'b0;
  logic [4:0]  wb_rd_addr_i = '0;
  logic        stall_o;
  logic        valid_o;
  issue_data_t out;
  reg_mask     pending_o;
  logic [31:0] hazard_cycles_o;

  hsv_core_issue_scoreboard dut (
    .clk_core(clk_core), .rst_core_n(rst_core_n), .flush_req(flush_req), .stall_i(stall_i),
    .valid_i(valid_i), .issue_data_i(issue_data_i), .mask_i(mask_i), .rd_mask_i(rd_mask_i),
    .wb_valid_i(wb_valid_i), .wb_rd_addr_i(wb_rd_addr_i), .stall_o(stall_o), .valid_o(valid_o),
    .out(out), .pending_o(pending_o), .hazard_cycles_o(hazard_cycles_o)
  );

  always #5 clk_core = ~clk_core;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;
  logic preload = 1'b0;

  // Model: pend[r] is true while register x[r] awaits a writeback.
  bit          pend [32];
  bit          m_valid = 1'b0;
  issue_data_t m_out = '0;
  logic [31:0] m_cnt = '0;

  function automatic reg_mask bm(input int r);
    return (r == 0) ? reg_mask'(0) : reg_mask'(1) << (r - 1);
  endfunction

  function automatic bit m_hazard();
    bit h = 1'b0;
    for (int r = 1; r < 32; r++) if (valid_i && mask_i[r-1] && pend[r]) h = 1'b1;
    return h;
  endfunction

  function automatic reg_mask m_pending();
    reg_mask m = '0;
    for (int r = 1; r < 32; r++) if (pend[r]) m |= bm(r);
    return m;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk_core or negedge rst_core_n or posedge preload) begin
    if (!rst_core_n) begin
      for (int r = 0; r < 32; r++) pend[r] = 1'b0;
      m_valid = 1'b0;
      m_out   = '0;
      m_cnt   = '0;
    end else if (preload) begin
      m_cnt = 32'hFFFF_FFFF;
    end else begin
      bit h, f;
      h = m_hazard();
      f = valid_i && !h && !stall_i && !flush_req;
      if (h && !flush_req) m_cnt = m_cnt + 1;
      if (flush_req) begin
        for (int r = 0; r < 32; r++) pend[r] = 1'b0;
        m_valid = 1'b0;
      end else begin
        if (!stall_i) m_valid = f;
        if (f) m_out = issue_data_i;
        if (wb_valid_i && wb_rd_addr_i != 0) pend[wb_rd_addr_i] = 1'b0;
        if (f) for (int r = 1; r < 32; r++) if (rd_mask_i[r-1]) pend[r] = 1'b1;
      end
    end
  end

  always @(negedge clk_core) begin
    if (chk_en) begin
      chk("valid_o", 64'(valid_o), 64'(m_valid));
      chk("out", 64'(out), 64'(m_out));
      chk("pending_o", 64'(pending_o), 64'(m_pending()));
      chk("hazard_cycles_o", 64'(hazard_cycles_o), 64'(m_cnt));
      chk("stall_o", 64'(stall_o), 64'(stall_i | m_hazard()));
    end
  end

  task automatic step();
    @(posedge clk_core);
    #1;
  endtask

  task automatic set_entry(input bit v, input int rd, input int rs1, input int rs2);
    valid_i      = v;
    mask_i       = bm(rd) | bm(rs1) | bm(rs2);
    rd_mask_i    = bm(rd);
    issue_data_i = {$urandom(), 7'($urandom()), 5'(rd), 5'(rs1), 5'(rs2)};
  endtask

  task automatic idle();
    valid_i = 1'b0; wb_valid_i = 1'b0; stall_i = 1'b0; flush_req = 1'b0;
  endtask

  initial begin
    #2 rst_core_n = 1'b0;
    #20;
    chk("reset valid_o", 64'(valid_o), 64'd0);
    chk("reset pending_o", 64'(pending_o), 64'd0);
    chk("reset hazard_cycles_o", 64'(hazard_cycles_o), 64'd0);
    chk("reset out", 64'(out), 64'd0);
    @(negedge clk_core); #1 rst_core_n = 1'b1;
    chk_en = 1'b1;
    step();
    // RAW hazard on x5, resolved by writeback
    set_entry(1, 5, 1, 2); step();
    chk("x5 fired", 64'(valid_o), 64'd1);
    set_entry(1, 6, 5, 0); #1;
    chk("raw stall_o", 64'(stall_o), 64'd1);
    step(); step();
    chk("raw hazard count", 64'(hazard_cycles_o), 64'd2);
    chk("raw pending x5", 64'(pending_o), 64'h10);
    wb_valid_i = 1'b1; wb_rd_addr_i = 5'd5; step();
    chk("wb cycle still hazard", 64'(hazard_cycles_o), 64'd3);
    chk("wb cycle no fire", 64'(valid_o), 64'd0);
    wb_valid_i = 1'b0; step();
    chk("dependent fired", 64'(valid_o), 64'd1);
    chk("pending x6", 64'(pending_o), 64'h20);
    // set beats clear on x7
    set_entry(1, 7, 1, 2); wb_valid_i = 1'b1; wb_rd_addr_i = 5'd6; step();
    chk("pending x7", 64'(pending_o), 64'h40);
    set_entry(1, 7, 1, 0); mask_i = bm(1); wb_rd_addr_i = 5'd7; step();
    chk("set wins x7", 64'(pending_o), 64'h40);
    valid_i = 1'b0; step();
    chk("x7 cleared", 64'(pending_o), 64'h0);
    // rd = x0 and writeback of x0
    set_entry(1, 0, 0, 0); wb_rd_addr_i = 5'd0; step();
    chk("x0 entry fired", 64'(valid_o), 64'd1);
    chk("x0 pending empty", 64'(pending_o), 64'h0);
    idle();
    // flush under stall with pending {x3, x9}
    set_entry(1, 3, 1, 2); step();
    set_entry(1, 9, 1, 2); step();
    valid_i = 1'b0; stall_i = 1'b1; step();
    chk("held under stall", 64'(valid_o), 64'd1);
    chk("pending x3 x9", 64'(pending_o), 64'h104);
    flush_req = 1'b1; step();
    chk("flush valid_o", 64'(valid_o), 64'd0);
    chk("flush pending", 64'(pending_o), 64'h0);
    idle(); set_entry(1, 4, 3, 9); #1;
    chk("post flush no stall", 64'(stall_o), 64'd0);
    step();
    chk("post flush fired", 64'(valid_o), 64'd1);
    // counter wrap, then async reset mid-stall
    set_entry(1, 5, 4, 0);
    force dut.hazard_cnt = 32'hFFFF_FFFF;
    preload = 1'b1;
    #1 preload = 1'b0;
    release dut.hazard_cnt;
    step();
    chk("counter wrap", 64'(hazard_cycles_o), 64'h0);
    #2 rst_core_n = 1'b0;
    #1;
    chk("async reset valid_o", 64'(valid_o), 64'd0);
    chk("async reset pending", 64'(pending_o), 64'h0);
    chk("async reset counter", 64'(hazard_cycles_o), 64'h0);
    chk("async reset out", 64'(out), 64'h0);
    @(negedge clk_core); #1 rst_core_n = 1'b1;
    step();
    chk("first after reset fires", 64'(valid_o), 64'd1);
    // random traffic on a small register window to provoke hazards
    for (int n = 0; n < 400; n++) begin
      set_entry($urandom_range(99) < 70, int'($urandom_range(7)), int'($urandom_range(7)),
                int'($urandom_range(7)));
      wb_valid_i   = $urandom_range(99) < 40;
      wb_rd_addr_i = 5'($urandom_range(7));
      stall_i      = $urandom_range(99) < 20;
      flush_req    = $urandom_range(99) < 5;
      step();
    end
    idle(); step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
